// File: rtl/i2s_serializer.sv
`timescale 1ns/1ps
// Master-mode I2S transmitter: one L/R PCM pair per frame, MSB first, WS one bit ahead of the slot MSB.
// Latency: a pair accepted before a frame load goes out in that frame; frames are 2*SLOT_WIDTH BCK long.
// Backpressure: one-deep holding register, sample_ready_o = holding empty; empty at load gives an underrun frame.
// Build option: `define I2S_SERIALIZER_UNDERRUN_ZERO_EN mutes underrun frames, otherwise the last pair repeats.
module i2s_serializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCK_DIV      = 4
) (
    input  logic                    AMCLK_i,
    input  logic                    ARST,
    input  logic [SAMPLE_WIDTH-1:0] sample_l_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_r_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    output logic                    ASCLK_o,
    output logic                    ALRCLK_o,
    output logic                    ASDATA_o,
    output logic                    frame_start_o,
    output logic                    underrun_o
);

    localparam int DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PAD        = SLOT_WIDTH - SAMPLE_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_BITS - 2);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shifter_q, shifter_d;
    logic                    asclk_q, asclk_d;
    logic                    alrclk_q, alrclk_d;
    logic                    asdata_q, asdata_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;
    logic                    full_q, full_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
`ifndef I2S_SERIALIZER_UNDERRUN_ZERO_EN
    logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d;
    logic [SAMPLE_WIDTH-1:0] last_r_q, last_r_d;
`endif

    logic                    tick;
    logic                    fall;
    logic                    accept;
    logic [SAMPLE_WIDTH-1:0] load_l;
    logic [SAMPLE_WIDTH-1:0] load_r;

    // Place a sample MSB-aligned in its slot with zero-padded LSBs.
    function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [SAMPLE_WIDTH-1:0] s);
        logic [SLOT_WIDTH-1:0] w;
        w = SLOT_WIDTH'(s);
        return w << PAD;
    endfunction

    // Next-state: bit clock divider, holding register handshake, and per-fall frame shifting.
    always_comb begin
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shifter_d     = shifter_q;
        asclk_d       = asclk_q;
        alrclk_d      = alrclk_q;
        asdata_d      = asdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        full_d        = full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
`ifndef I2S_SERIALIZER_UNDERRUN_ZERO_EN
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
`endif
        load_l        = '0;
        load_r        = '0;

        tick   = (div_cnt_q == DIV_LAST);
        fall   = tick && asclk_q;
        accept = sample_valid_i && !full_q;

        if (tick) begin
            div_cnt_d = '0;
            asclk_d   = !asclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // Accept only when empty, so it can never collide with a load that drains a full register.
        if (accept) begin
            full_d   = 1'b1;
            hold_l_d = sample_l_i;
            hold_r_d = sample_r_i;
        end

        if (fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            // WS leads the slot MSB by one bit clock.
            alrclk_d  = (bit_cnt_d >= WS_FIRST) && (bit_cnt_d <= WS_LAST);
            if (bit_cnt_d == '0) begin
                frame_start_d = 1'b1;
                if (full_q) begin
                    load_l = hold_l_q;
                    load_r = hold_r_q;
                    full_d = 1'b0;
`ifndef I2S_SERIALIZER_UNDERRUN_ZERO_EN
                    last_l_d = hold_l_q;
                    last_r_d = hold_r_q;
`endif
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_SERIALIZER_UNDERRUN_ZERO_EN
                    load_l = '0;
                    load_r = '0;
`else
                    load_l = last_l_q;
                    load_r = last_r_q;
`endif
                end
                shifter_d = {to_slot(load_l), to_slot(load_r)};
            end else begin
                shifter_d = shifter_q << 1;
            end
            asdata_d = shifter_d[FRAME_BITS-1];
        end
    end

    // State registers with synchronous reset; reset aborts any frame and drops a held pair.
    always_ff @(posedge AMCLK_i) begin
        if (ARST) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= BIT_LAST;
            shifter_q     <= '0;
            asclk_q       <= 1'b0;
            alrclk_q      <= 1'b0;
            asdata_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            full_q        <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
`ifndef I2S_SERIALIZER_UNDERRUN_ZERO_EN
            last_l_q      <= '0;
            last_r_q      <= '0;
`endif
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shifter_q     <= shifter_d;
            asclk_q       <= asclk_d;
            alrclk_q      <= alrclk_d;
            asdata_q      <= asdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            full_q        <= full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
`ifndef I2S_SERIALIZER_UNDERRUN_ZERO_EN
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
`endif
        end
    end

    assign sample_ready_o = !full_q;
    assign ASCLK_o        = asclk_q;
    assign ALRCLK_o       = alrclk_q;
    assign ASDATA_o       = asdata_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_i2s_serializer.sv
`timescale 1ns/1ps
// Bench for i2s_serializer with BCK_DIV=2, SLOT_WIDTH=32, SAMPLE_WIDTH=24.
// Frames are captured bit by bit after each ASCLK fall and compared to hand-derived pairs.
// Producer drives at negedges; all sampling is done at negedges.
module tb_i2s_serializer;

    localparam int SW = 24;
    localparam int SL = 32;
    localparam int BD = 2;
    localparam logic [63:0] WS_PAT = 64'h0000_0001_FFFF_FFFE;
`ifdef I2S_SERIALIZER_UNDERRUN_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [SW-1:0] sl = '0;
    logic [SW-1:0] sr = '0;
    logic          sv = 1'b0;
    logic          sample_ready_o, ASCLK_o, ALRCLK_o, ASDATA_o, frame_start_o, underrun_o;

    int checks = 0;
    int errors = 0;

    i2s_serializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCK_DIV(BD)) dut (
        .AMCLK_i        (clk),
        .ARST           (arst),
        .sample_l_i     (sl),
        .sample_r_i     (sr),
        .sample_valid_i (sv),
        .sample_ready_o (sample_ready_o),
        .ASCLK_o        (ASCLK_o),
        .ALRCLK_o       (ALRCLK_o),
        .ASDATA_o       (ASDATA_o),
        .frame_start_o  (frame_start_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        bit          push;
        logic [23:0] l;
        logic [23:0] r;
        bit          exp_ur;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    // Underrun frames repeat the given pair unless the mute build is selected.
    function automatic logic [63:0] expect_frame(input bit ur, input logic [23:0] l, input logic [23:0] r);
        if (ur && ZERO_EN) return 64'h0;
        return frame_of(l, r);
    endfunction

    task automatic get_frame(output logic [63:0] d, output logic [63:0] ws, output logic ur,
                             output int wait_n, output int clk_err);
        wait_n = 0;
        clk_err = 0;
        d = 'x;
        ws = 'x;
        ur = 1'bx;
        while (frame_start_o !== 1'b1 && wait_n < 600) begin
            @(negedge clk);
            wait_n++;
        end
        if (frame_start_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_start_o after %0d cycles expected within 600", wait_n);
            return;
        end
        ur = underrun_o;
        d[63] = ASDATA_o;
        ws[63] = ALRCLK_o;
        for (int i = 62; i >= 0; i--) begin
            repeat (2) @(negedge clk);
            if (ASCLK_o !== 1'b1) clk_err++;
            repeat (2) @(negedge clk);
            if (ASCLK_o !== 1'b0) clk_err++;
            d[i] = ASDATA_o;
            ws[i] = ALRCLK_o;
        end
    endtask

    task automatic check_frame(input string name, input bit exp_ur, input logic [63:0] exp_d,
                               output int wait_n);
        logic [63:0] d, ws;
        logic ur;
        int ce;
        get_frame(d, ws, ur, wait_n, ce);
        check({name, "_underrun"}, 64'(ur), 64'(exp_ur));
        check({name, "_data"}, d, exp_d);
        check({name, "_ws"}, ws, WS_PAT);
        check({name, "_asclk"}, 64'(ce), 64'd0);
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        sl = l;
        sr = r;
        sv = 1'b1;
        while (!sample_ready_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got ready low for %0d cycles expected high within 600", n);
        end
        @(negedge clk);
        sv = 1'b0;
    endtask

    initial begin
        logic [3:0]  asq, fsq;
        logic [23:0] pl[3];
        logic [23:0] pr[3];
        int w;

        vecs[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{1'b0, 24'h000000, 24'h000000, 1'b1, 24'hA5A5A5, 24'h5A5A5A};
        vecs[2] = '{1'b1, 24'h123456, 24'hFEDCBA, 1'b0, 24'h123456, 24'hFEDCBA};
        vecs[3] = '{1'b1, 24'h800000, 24'h7FFFFF, 1'b0, 24'h800000, 24'h7FFFFF};
        vecs[4] = '{1'b0, 24'h000000, 24'h000000, 1'b1, 24'h800000, 24'h7FFFFF};
        vecs[5] = '{1'b1, 24'hFFFFFF, 24'h000001, 1'b0, 24'hFFFFFF, 24'h000001};
        pl[0] = 24'h111111; pr[0] = 24'h222222;
        pl[1] = 24'h333333; pr[1] = 24'h444444;
        pl[2] = 24'h555555; pr[2] = 24'h666666;

        // Reset values, then idle startup timing and empty frames.
        arst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({ASCLK_o, ALRCLK_o, ASDATA_o, frame_start_o, underrun_o, sample_ready_o}),
              64'(6'b000001));
        arst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            asq[3-c] = ASCLK_o;
            fsq[3-c] = frame_start_o;
        end
        check("asclk_startup", 64'(asq), 64'(4'b0110));
        check("first_frame_start", 64'(fsq), 64'(4'b0001));
        check_frame("idle_f0", 1'b1, 64'h0, w);
        check_frame("idle_f1", 1'b1, 64'h0, w);
        check("frame_period", 64'(w), 64'd4);

        // Table of frames: optional push before each frame, expected frame contents.
        for (int k = 0; k < 6; k++) begin
            if (vecs[k].push) push(vecs[k].l, vecs[k].r);
            check_frame($sformatf("vec%0d", k), vecs[k].exp_ur,
                        expect_frame(vecs[k].exp_ur, vecs[k].exp_l, vecs[k].exp_r), w);
        end

        // Valid held high across three pairs: each sent once, in order, ready low while held.
        fork
            begin
                int n;
                for (int k = 0; k < 3; k++) begin
                    sl = pl[k];
                    sr = pr[k];
                    sv = 1'b1;
                    n = 0;
                    while (!sample_ready_o && n < 600) begin
                        @(negedge clk);
                        n++;
                    end
                    check($sformatf("stream_ready_seen%0d", k), 64'(sample_ready_o), 64'd1);
                    @(negedge clk);
                    check($sformatf("stream_ready_low%0d", k), 64'(sample_ready_o), 64'd0);
                end
                sv = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++)
                    check_frame($sformatf("stream%0d", k), 1'b0, frame_of(pl[k], pr[k]), w);
                check_frame("stream_drain", 1'b1, expect_frame(1'b1, pl[2], pr[2]), w);
            end
        join

        // Valid arrives on the exact load cycle while empty: underrun now, pair next frame.
        repeat (3) @(negedge clk);
        sl = 24'hC0FFEE;
        sr = 24'h0BEEF0;
        sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        check("collide_accepted", 64'(sample_ready_o), 64'd0);
        check_frame("collide_load", 1'b1, expect_frame(1'b1, pl[2], pr[2]), w);
        check_frame("collide_next", 1'b0, frame_of(24'hC0FFEE, 24'h0BEEF0), w);

        // Reset in the right slot with a pair pending: everything returns to reset values.
        push(24'h9ABCDE, 24'h13579B);
        w = 0;
        while (frame_start_o !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
        end
        repeat (160) @(negedge clk);
        check("right_slot_ws", 64'(ALRCLK_o), 64'd1);
        push(24'h2468AC, 24'hFDB975);
        arst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs",
              64'({ASCLK_o, ALRCLK_o, ASDATA_o, frame_start_o, underrun_o, sample_ready_o}),
              64'(6'b000001));
        repeat (2) @(negedge clk);
        arst = 1'b0;
        check_frame("after_reset", 1'b1, 64'h0, w);
        check("after_reset_first_fall", 64'(w), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
